// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program ROM address/data, execute redirect, and the decode handshake.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  fetch_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    input  fetch_enable, mem_data, redirect_valid, redirect_target, out_ready,
    output mem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output fetch_enable, mem_data, redirect_valid, redirect_target, out_ready,
    input  mem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, one in-flight ROM read, 2-entry {pc, instr} queue toward decode, redirects.
module instruction_fetch #(
  parameter int unsigned         ADDR_WIDTH   = 11,
  parameter int unsigned         DATA_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  instruction_fetch_if.master bus
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0] tail_pc;
  logic [DATA_WIDTH-1:0] tail_instr;
  logic                  pop;
  logic                  push;
  logic                  issue;

  always_comb begin
    pop   = (count != 2'd0) && bus.out_ready;
    push  = inflight && !bus.redirect_valid;
    // count + inflight - pop <= 1 keeps room for every word already requested
    issue = bus.redirect_valid ||
            (bus.fetch_enable &&
             (({1'b0, count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop})));
    if (!reset_n) begin
      fetch_addr = RESET_VECTOR;
    end else if (bus.redirect_valid) begin
      fetch_addr = bus.redirect_target;
    end else begin
      fetch_addr = pc;
    end
  end

  assign bus.mem_addr  = fetch_addr;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = head_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      head_pc     <= '0;
      head_instr  <= '0;
      tail_pc     <= '0;
      tail_instr  <= '0;
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_addr;
        pc          <= fetch_addr + ADDR_WIDTH'(1);
      end else begin
        inflight    <= 1'b0;
      end

      // A redirect drops the queue and the word returning this cycle
      if (bus.redirect_valid) begin
        count <= 2'd0;
      end else begin
        case (count)
          2'd0: begin
            if (push) begin
              head_pc    <= inflight_pc;
              head_instr <= bus.mem_data;
              count      <= 2'd1;
            end
          end
          2'd1: begin
            if (push && pop) begin
              head_pc    <= inflight_pc;
              head_instr <= bus.mem_data;
            end else if (push) begin
              tail_pc    <= inflight_pc;
              tail_instr <= bus.mem_data;
              count      <= 2'd2;
            end else if (pop) begin
              count      <= 2'd0;
            end
          end
          2'd2: begin
            if (pop) begin
              head_pc    <= tail_pc;
              head_instr <= tail_instr;
              if (push) begin
                tail_pc    <= inflight_pc;
                tail_instr <= bus.mem_data;
              end else begin
                count      <= 2'd1;
              end
            end
          end
          default: count <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: cycle table for startup/backpressure/enable,
// scoreboard of delivered {pc, instr}, and hand sequences for redirect, wrap and reset.
module tb_instruction_fetch;

  logic clock;
  logic reset_n;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program ROM model: registered read, ROM[i] = 0x1000 + i
  always @(posedge clock) bus.mem_data <= 16'h1000 + 16'(bus.mem_addr);

  typedef struct {
    logic [10:0] pc;
    logic [15:0] instr;
  } exp_t;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic [10:0] addr;
    logic        valid;
    logic [10:0] pc;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[15];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_pops = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic expect_from(input logic [10:0] start, input int n);
    logic [10:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 11'(i);
      exp_q.push_back('{pc: a, instr: 16'h1000 + 16'(a)});
    end
  endtask

  // Scoreboard: every transfer to decode must be the next expected word
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      n_pops++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pop: got pc=%0h instr=%0h, want no transfer",
                 bus.out_pc, bus.out_instr);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          n_err++;
          $display("FAIL stream: got pc=%0h instr=%0h, want pc=%0h instr=%0h",
                   bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_seq(input logic [10:0] tgt, input logic rdy);
    bus.out_ready       = rdy;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = tgt;
    @(negedge clock);
    check("redir_addr", 32'(bus.mem_addr), 32'(tgt));
    step();
    bus.redirect_valid = 1'b0;
    expect_from(tgt, 32);
    @(negedge clock);
    check("redir_gap_valid", 32'(bus.out_valid), 32'd0);
    check("redir_gap_addr", 32'(bus.mem_addr), 32'(tgt + 11'd1));
    step();
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("redir_first_valid", 32'(bus.out_valid), 32'd1);
    check("redir_first_pc", 32'(bus.out_pc), 32'(tgt));
    check("redir_first_instr", 32'(bus.out_instr), 32'(16'h1000 + 16'(tgt)));
    step();
  endtask

  initial begin
    int pops0;

    // fe, rdy, mem_addr, out_valid, out_pc -- cycle k after reset release
    tbl[0]  = '{1'b1, 1'b1, 11'd0, 1'b0, 11'd0};
    tbl[1]  = '{1'b1, 1'b1, 11'd1, 1'b0, 11'd0};
    tbl[2]  = '{1'b1, 1'b1, 11'd2, 1'b1, 11'd0};
    tbl[3]  = '{1'b1, 1'b0, 11'd3, 1'b1, 11'd1};
    tbl[4]  = '{1'b1, 1'b0, 11'd3, 1'b1, 11'd1};
    tbl[5]  = '{1'b1, 1'b0, 11'd3, 1'b1, 11'd1};
    tbl[6]  = '{1'b1, 1'b1, 11'd3, 1'b1, 11'd1};
    tbl[7]  = '{1'b1, 1'b1, 11'd4, 1'b1, 11'd2};
    tbl[8]  = '{1'b1, 1'b1, 11'd5, 1'b1, 11'd3};
    tbl[9]  = '{1'b0, 1'b1, 11'd6, 1'b1, 11'd4};
    tbl[10] = '{1'b0, 1'b1, 11'd6, 1'b1, 11'd5};
    tbl[11] = '{1'b0, 1'b1, 11'd6, 1'b0, 11'd0};
    tbl[12] = '{1'b1, 1'b1, 11'd6, 1'b0, 11'd0};
    tbl[13] = '{1'b1, 1'b1, 11'd7, 1'b0, 11'd0};
    tbl[14] = '{1'b1, 1'b1, 11'd8, 1'b1, 11'd6};

    reset_n             = 1'b0;
    bus.fetch_enable    = 1'b1;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    expect_from(11'd0, 64);
    step();
    step();
    @(negedge clock);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_pc", 32'(bus.out_pc), 32'd0);
    check("reset_instr", 32'(bus.out_instr), 32'd0);
    step();
    reset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      bus.fetch_enable = tbl[k].fe;
      bus.out_ready    = tbl[k].rdy;
      @(negedge clock);
      check($sformatf("tbl%0d_addr", k), 32'(bus.mem_addr), 32'(tbl[k].addr));
      check($sformatf("tbl%0d_valid", k), 32'(bus.out_valid), 32'(tbl[k].valid));
      if (tbl[k].valid) begin
        check($sformatf("tbl%0d_pc", k), 32'(bus.out_pc), 32'(tbl[k].pc));
        check($sformatf("tbl%0d_instr", k), 32'(bus.out_instr),
              32'(16'h1000 + 16'(tbl[k].pc)));
      end
      step();
    end

    // Redirect while the queue is full and decode is stalled
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    @(negedge clock);
    check("full_before_redir", 32'(bus.out_valid), 32'd1);
    step();
    redirect_seq(11'h040, 1'b0);
    pops0 = n_pops;
    repeat (6) step();
    check("redir_throughput", 32'(n_pops - pops0), 32'd6);

    // Wrap; the old head pops in the redirect cycle and must still be in order
    redirect_seq(11'h7FE, 1'b1);
    pops0 = n_pops;
    repeat (4) step();
    check("wrap_pops", 32'(n_pops - pops0), 32'd4);

    // Back-to-back redirects: only the second target is delivered
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 11'h100;
    step();
    bus.redirect_target = 11'h200;
    step();
    bus.redirect_valid = 1'b0;
    expect_from(11'h200, 32);
    @(negedge clock);
    check("b2b_gap_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clock);
    check("b2b_first_pc", 32'(bus.out_pc), 32'h200);
    pops0 = n_pops;
    repeat (3) step();
    check("b2b_pops", 32'(n_pops - pops0), 32'd3);

    // Asynchronous reset mid-operation with a full queue
    bus.out_ready = 1'b0;
    repeat (3) step();
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_addr", 32'(bus.mem_addr), 32'd0);
    check("async_reset_pc", 32'(bus.out_pc), 32'd0);
    expect_from(11'd0, 32);
    step();
    step();
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("restart_addr0", 32'(bus.mem_addr), 32'd0);
    step();
    @(negedge clock);
    check("restart_valid_early", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clock);
    check("restart_valid", 32'(bus.out_valid), 32'd1);
    check("restart_pc", 32'(bus.out_pc), 32'd0);
    pops0 = n_pops;
    repeat (4) step();
    check("restart_pops", 32'(n_pops - pops0), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
